// File: rtl/mod_updown_counter_if.sv
// Bus bundle for mod_updown_counter: control strobes in, count and status flags out.
// WIDTH must match the counter instance it connects to.
interface mod_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             i_enable;
  logic             i_up;
  logic             i_load;
  logic [WIDTH-1:0] i_load_value;
  logic [WIDTH-1:0] o_counter_value;
  logic             o_terminal_count;
  logic             o_wrapped;
  logic             o_overflow;

  modport master (
    output i_enable, i_up, i_load, i_load_value,
    input  o_counter_value, o_terminal_count, o_wrapped, o_overflow
  );

  modport slave (
    input  i_enable, i_up, i_load, i_load_value,
    output o_counter_value, o_terminal_count, o_wrapped, o_overflow
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Up/down modulo-(MAX_COUNT+1) counter with parallel load, wrap pulse, sticky overflow and cascade output.
// Define COUNTER_SATURATE_EN to hold at the boundaries instead of wrapping.
module mod_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mod_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] LP_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] LP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Loads beyond the modulus are clamped so the register never leaves 0..MAX_COUNT.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
    logic [WIDTH-1:0] result;
    if (value > LP_MAX) begin
      result = LP_MAX;
    end else begin
      result = value;
    end
    return result;
  endfunction

  logic [WIDTH-1:0] r_count;
  logic             r_wrapped;
  logic             r_overflow;

  logic [WIDTH-1:0] w_step_count;
  logic             w_step_wrap;
  logic             w_step_block;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_count == LP_MAX);
  assign w_at_zero = (r_count == LP_ZERO);

  // Next value for an enabled step, plus whether that step wrapped or was blocked.
  always_comb begin
    w_step_count = r_count;
    w_step_wrap  = 1'b0;
    w_step_block = 1'b0;
    if (bus.i_up) begin
      if (r_count < LP_MAX) begin
        w_step_count = r_count + LP_ONE;
      end else begin
`ifdef COUNTER_SATURATE_EN
        w_step_count = LP_MAX;
        w_step_block = 1'b1;
`else
        w_step_count = LP_ZERO;
        w_step_wrap  = 1'b1;
`endif
      end
    end else begin
      if (w_at_zero) begin
`ifdef COUNTER_SATURATE_EN
        w_step_count = LP_ZERO;
        w_step_block = 1'b1;
`else
        w_step_count = LP_MAX;
        w_step_wrap  = 1'b1;
`endif
      end else if (r_count > LP_MAX) begin
        // Corrupted value: land on the boundary rather than step through illegal codes.
        w_step_count = LP_MAX;
      end else begin
        w_step_count = r_count - LP_ONE;
      end
    end
  end

  // Count, wrap pulse and sticky overflow; priority reset > load > enable > hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count    <= LP_ZERO;
      r_wrapped  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.i_load) begin
      r_count    <= clamp_load(bus.i_load_value);
      r_wrapped  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.i_enable) begin
      r_count    <= w_step_count;
      r_wrapped  <= w_step_wrap;
      r_overflow <= r_overflow | w_step_wrap | w_step_block;
    end else begin
      r_count    <= r_count;
      r_wrapped  <= 1'b0;
      r_overflow <= r_overflow;
    end
  end

  // Terminal count stays combinational so it can enable the next stage on the same edge.
  assign bus.o_terminal_count = bus.i_enable & ((bus.i_up & w_at_max) | (~bus.i_up & w_at_zero));
  assign bus.o_counter_value  = r_count;
  assign bus.o_wrapped        = r_wrapped;
  assign bus.o_overflow       = r_overflow;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four instances (8-bit, mod-10, and a two-digit BCD cascade)
// checked every cycle against an arithmetic model plus hand-computed literal expectations.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic [3:0] rst_v = 4'hF;
  logic [3:0] en_v  = 4'h0;
  logic [3:0] up_v  = 4'h0;
  logic [3:0] ld_v  = 4'h0;
  logic [7:0] lv_v [4];

  int  checks   = 0;
  int  failures = 0;
  bit  model_valid = 1'b0;
  int  m_cv [4];
  bit  m_wr [4];
  bit  m_ov [4];

  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(8)) if0 ();
  mod_updown_counter_if #(.WIDTH(4)) if1 ();
  mod_updown_counter_if #(.WIDTH(4)) if2 ();
  mod_updown_counter_if #(.WIDTH(4)) if3 ();

  assign if0.i_enable = en_v[0];  assign if0.i_up = up_v[0];
  assign if0.i_load   = ld_v[0];  assign if0.i_load_value = lv_v[0];
  assign if1.i_enable = en_v[1];  assign if1.i_up = up_v[1];
  assign if1.i_load   = ld_v[1];  assign if1.i_load_value = lv_v[1][3:0];
  assign if2.i_enable = en_v[2];  assign if2.i_up = up_v[2];
  assign if2.i_load   = ld_v[2];  assign if2.i_load_value = lv_v[2][3:0];
  assign if3.i_enable = if2.o_terminal_count;  assign if3.i_up = up_v[3];
  assign if3.i_load   = ld_v[3];  assign if3.i_load_value = lv_v[3][3:0];

  mod_updown_counter #(.WIDTH(8))                 u0 (.i_clk(clk), .i_rst(rst_v[0]), .bus(if0));
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9))  u1 (.i_clk(clk), .i_rst(rst_v[1]), .bus(if1));
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9))  u2 (.i_clk(clk), .i_rst(rst_v[2]), .bus(if2));
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9))  u3 (.i_clk(clk), .i_rst(rst_v[2]), .bus(if3));

  logic [7:0] d_cv [4];
  logic [3:0] d_tc, d_wr, d_ov;
  assign d_cv[0] = if0.o_counter_value;
  assign d_cv[1] = {4'h0, if1.o_counter_value};
  assign d_cv[2] = {4'h0, if2.o_counter_value};
  assign d_cv[3] = {4'h0, if3.o_counter_value};
  assign d_tc = {if3.o_terminal_count, if2.o_terminal_count, if1.o_terminal_count, if0.o_terminal_count};
  assign d_wr = {if3.o_wrapped, if2.o_wrapped, if1.o_wrapped, if0.o_wrapped};
  assign d_ov = {if3.o_overflow, if2.o_overflow, if1.o_overflow, if0.o_overflow};

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- behavioural model ----------------
  function automatic int maxv(input int k);
    return (k == 0) ? 255 : 9;
  endfunction

  function automatic bit rst_of(input int k);
    return (k == 3) ? rst_v[2] : rst_v[k];
  endfunction

  function automatic bit boundary(input int k);
    return up_v[k] ? (m_cv[k] == maxv(k)) : (m_cv[k] == 0);
  endfunction

  function automatic bit tc_of(input int k, input bit e);
    return e && boundary(k);
  endfunction

  function automatic bit en_eff(input int k);
    return (k == 3) ? tc_of(2, en_v[2]) : en_v[k];
  endfunction

  function automatic int nxt_cv(input int k);
    int m;
    m = maxv(k);
    if (rst_of(k)) return 0;
    if (ld_v[k]) return (int'(lv_v[k]) > m) ? m : int'(lv_v[k]);
    if (!en_eff(k)) return m_cv[k];
    if (SAT && boundary(k)) return m_cv[k];
    return up_v[k] ? (m_cv[k] + 1) % (m + 1) : (m_cv[k] + m) % (m + 1);
  endfunction

  function automatic bit nxt_wr(input int k);
    if (rst_of(k) || ld_v[k]) return 1'b0;
    return en_eff(k) && boundary(k) && !SAT;
  endfunction

  function automatic bit nxt_ov(input int k);
    if (rst_of(k) || ld_v[k]) return 1'b0;
    if (en_eff(k) && boundary(k)) return 1'b1;
    return m_ov[k];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      m_cv[k] <= nxt_cv(k);
      m_wr[k] <= nxt_wr(k);
      m_ov[k] <= nxt_ov(k);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("model_cv%0d", k), {24'h0, d_cv[k]}, m_cv[k]);
        chk($sformatf("model_tc%0d", k), {31'h0, d_tc[k]}, {31'h0, tc_of(k, en_eff(k))});
        chk($sformatf("model_wr%0d", k), {31'h0, d_wr[k]}, {31'h0, m_wr[k]});
        chk($sformatf("model_ov%0d", k), {31'h0, d_ov[k]}, {31'h0, m_ov[k]});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int wcnt;
    for (int k = 0; k < 4; k++) lv_v[k] = 8'h00;
    cyc(1);
    model_valid = 1'b1;
    chk("reset_cv0", {24'h0, d_cv[0]}, 32'd0);
    chk("reset_flags", {28'h0, d_wr | d_ov}, 32'd0);
    rst_v = 4'h0;

    // 8-bit full sweep
    en_v[0] = 1'b1; up_v[0] = 1'b1;
    wcnt = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1);
      if (i == 254) chk("sweep_255", {24'h0, d_cv[0]}, 32'd255);
      if (d_wr[0] === 1'b1) wcnt++;
    end
    chk("sweep_end_cv", {24'h0, d_cv[0]}, SAT ? 32'd255 : 32'd0);
    chk("sweep_end_wr", {31'h0, d_wr[0]}, SAT ? 32'd0 : 32'd1);
    chk("sweep_end_ov", {31'h0, d_ov[0]}, 32'd1);
    en_v[0] = 1'b0;
    cyc(1);
    if (d_wr[0] === 1'b1) wcnt++;
    chk("sweep_wrap_pulses", wcnt, SAT ? 32'd0 : 32'd1);
    chk("sweep_hold_ov", {31'h0, d_ov[0]}, 32'd1);

    // mod-10 up count
    en_v[1] = 1'b1; up_v[1] = 1'b1;
    cyc(9);
    chk("mod10_at9", {24'h0, d_cv[1]}, 32'd9);
    chk("mod10_tc9", {31'h0, d_tc[1]}, 32'd1);
    cyc(1);
    chk("mod10_wrap_cv", {24'h0, d_cv[1]}, SAT ? 32'd9 : 32'd0);

    // mod-10 down from 0
    en_v[1] = 1'b0; rst_v[1] = 1'b1;
    cyc(1);
    rst_v[1] = 1'b0; en_v[1] = 1'b1; up_v[1] = 1'b0;
    #1 chk("down_tc0", {31'h0, d_tc[1]}, 32'd1);
    cyc(1);
    chk("down_cv1", {24'h0, d_cv[1]}, SAT ? 32'd0 : 32'd9);
    chk("down_wr1", {31'h0, d_wr[1]}, SAT ? 32'd0 : 32'd1);
    cyc(1);
    chk("down_cv2", {24'h0, d_cv[1]}, SAT ? 32'd0 : 32'd8);
    chk("down_wr2", {31'h0, d_wr[1]}, 32'd0);
    cyc(1);
    chk("down_cv3", {24'h0, d_cv[1]}, SAT ? 32'd0 : 32'd7);

    // load clamps and overrides enable; reset overrides load
    ld_v[1] = 1'b1; lv_v[1] = 8'd12;
    cyc(1);
    chk("load_clamp_cv", {24'h0, d_cv[1]}, 32'd9);
    chk("load_clamp_ov", {31'h0, d_ov[1]}, 32'd0);
    rst_v[1] = 1'b1;
    cyc(1);
    chk("rst_over_load", {24'h0, d_cv[1]}, 32'd0);
    rst_v[1] = 1'b0; ld_v[1] = 1'b0; lv_v[1] = 8'd0;

    // saturation / wrap at the top of mod-10
    up_v[1] = 1'b1;
    cyc(9);
    chk("top_cv9", {24'h0, d_cv[1]}, 32'd9);
    chk("top_ov_clear", {31'h0, d_ov[1]}, 32'd0);
    cyc(1);
    chk("top_cv_next", {24'h0, d_cv[1]}, SAT ? 32'd9 : 32'd0);
    chk("top_ov_set", {31'h0, d_ov[1]}, 32'd1);
    cyc(2);
    chk("top_cv_after", {24'h0, d_cv[1]}, SAT ? 32'd9 : 32'd2);
    chk("top_wr_after", {31'h0, d_wr[1]}, 32'd0);
    en_v[1] = 1'b0;

    // BCD cascade 99 -> 00
    ld_v[2] = 1'b1; ld_v[3] = 1'b1; lv_v[2] = 8'd9; lv_v[3] = 8'd9;
    up_v[2] = 1'b1; up_v[3] = 1'b1;
    cyc(1);
    ld_v[2] = 1'b0; ld_v[3] = 1'b0; en_v[2] = 1'b1;
    #1 chk("bcd_hi_tc", {31'h0, d_tc[3]}, 32'd1);
    cyc(1);
    chk("bcd_lo_cv", {24'h0, d_cv[2]}, SAT ? 32'd9 : 32'd0);
    chk("bcd_hi_cv", {24'h0, d_cv[3]}, SAT ? 32'd9 : 32'd0);
    chk("bcd_hi_wr", {31'h0, d_wr[3]}, SAT ? 32'd0 : 32'd1);
    en_v[2] = 1'b0;
    cyc(1);
    chk("bcd_hi_wr_once", {31'h0, d_wr[3]}, 32'd0);

    // count to 57 then reset mid-count
    rst_v[2] = 1'b1;
    cyc(1);
    rst_v[2] = 1'b0; en_v[2] = 1'b1;
    cyc(57);
    chk("bcd57_lo", {24'h0, d_cv[2]}, SAT ? 32'd9 : 32'd7);
    chk("bcd57_hi", {24'h0, d_cv[3]}, SAT ? 32'd9 : 32'd5);
    rst_v[2] = 1'b1;
    cyc(1);
    chk("bcd_rst_lo", {24'h0, d_cv[2]}, 32'd0);
    chk("bcd_rst_hi", {24'h0, d_cv[3]}, 32'd0);
    rst_v[2] = 1'b0; en_v[2] = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised synchronous up/down counter with programmable modulus, parallel load and a cascade output. It generalises the team's fixed 8-bit enable-only counter to arbitrary width and wrap value, adds direction control and load, and provides a terminal-count output for chaining stages (rate dividers, BCD digit chains, timers).

## Interface
- WIDTH, default 8: counter width in bits (≥ 2).
- MAX_COUNT, default 2**WIDTH-1: highest count value; the counter spans 0..MAX_COUNT; must satisfy 1 ≤ MAX_COUNT ≤ 2**WIDTH-1.

- Clock  input  1  rising-edge clock; only clock.
- Reset  input  1  synchronous, active-high reset.
- Enable  input  1  count enable; one step per enabled edge.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Load  input  1  parallel load strobe.
- LoadValue  input  WIDTH  value loaded when Load = 1.
- CounterValue  output  WIDTH  current count, registered.
- TerminalCount  output  1  combinational: Enable & ((Up & CounterValue==MAX_COUNT) | (~Up & CounterValue==0)).
- Wrapped  output  1  registered one-cycle pulse after any edge on which the count wrapped.
- Overflow  output  1  sticky flag, set on any wrap (or saturation hit), cleared only by Reset or Load.

## Operation
- Priority per rising edge: Reset > Load > Enable > hold.
- Reset: CounterValue = 0, Wrapped = 0, Overflow = 0.
- Load: CounterValue = min(LoadValue, MAX_COUNT); Wrapped = 0; Overflow = 0; Enable ignored that edge.
- Enable & Up: CounterValue < MAX_COUNT → +1; CounterValue == MAX_COUNT → 0, Wrapped = 1, Overflow = 1.
- Enable & ~Up: CounterValue > 0 → −1; CounterValue == 0 → MAX_COUNT, Wrapped = 1, Overflow = 1.
- Enable = 0: CounterValue holds; Wrapped = 0; Overflow holds.
- Wrapped is 0 on every edge without a wrap.
- Up may change every cycle; the direction sampled on the edge is the direction applied.
- Cascade: stage N+1 Enable = stage N TerminalCount; all stages share Clock and Reset.
- Arithmetic is modulo MAX_COUNT+1; no intermediate value outside 0..MAX_COUNT is ever registered.
- Out-of-range value (only reachable via X/corruption) increments or decrements into 0 or MAX_COUNT on the next enabled edge as if at boundary; bench does not rely on it.

## Timing
- CounterValue updates 1 cycle after the qualifying edge inputs; no further latency.
- TerminalCount is combinational from Enable, Up and CounterValue; valid in the same cycle, for use as the next stage's Enable.
- Wrapped and Overflow are registered: assert in the cycle after the wrap edge.
- Reset asserted mid-count takes effect on the next edge regardless of Load/Enable; all outputs zero (TerminalCount = Enable & ~Up while CounterValue = 0).
- Simultaneous Load and Enable: load wins, no step, no wrap.

## Configuration
- Macro COUNTER_SATURATE_EN.
- Undefined (default): wrap-around behaviour as above.
- Defined: at MAX_COUNT counting up, or at 0 counting down, CounterValue holds; Wrapped never asserts; Overflow sets on the first such blocked step; TerminalCount definition unchanged.

## Test plan
- WIDTH=8, default MAX_COUNT: Reset, Enable=1, Up=1 for 256 edges → CounterValue 0..255 then 0; Wrapped pulses once, cycle after the 255→0 edge; Overflow = 1 afterwards.
- WIDTH=4, MAX_COUNT=9: count up from 0 → sequence 0..9,0; TerminalCount high only while value = 9 with Enable = 1.
- WIDTH=4, MAX_COUNT=9, Up=0 from 0 → next value 9, Wrapped = 1 next cycle; then 8, 7.
- Load with LoadValue=12, MAX_COUNT=9, Enable=1 simultaneously → CounterValue = 9, Overflow = 0, no step; Reset together with Load → CounterValue = 0.
- Two cascaded WIDTH=4 MAX_COUNT=9 stages (BCD) counting 99 → 00; upper Wrapped pulses once; Reset mid-count at 57 → 00 on next edge.
- COUNTER_SATURATE_EN defined, MAX_COUNT=9: count up to 9, 3 more enabled edges → holds 9, Wrapped stays 0, Overflow = 1 from the first blocked step.
